// File: rtl/kb_pkg.sv
// kb_pkg: Set-2 scancode constants, game key indices and decoder FSM states.
package kb_pkg;

    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_E1 = 8'hE1;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_FF = 8'hFF;
    localparam logic [7:0] SC_FA = 8'hFA;
    localparam logic [7:0] SC_AA = 8'hAA;
    localparam logic [7:0] SC_EE = 8'hEE;

    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_P     = 8'h4D;

    localparam int NUM_KEYS = 5;
    localparam int K_SPACE  = 0;
    localparam int K_UP     = 1;
    localparam int K_ENTER  = 2;
    localparam int K_ESC    = 3;
    localparam int K_P      = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK,
        S_SKIP
    } state_t;

endpackage

// File: rtl/kb_key_map.sv
// kb_key_map: maps {extended flag, Set-2 code} to a one-hot game key; all-zero when unmapped.
module kb_key_map
    import kb_pkg::*;
(
    input  logic                ext,
    input  logic [7:0]          code,
    output logic [NUM_KEYS-1:0] key
);

    always_comb begin
        key          = '0;
        key[K_SPACE] = !ext && code == SC_SPACE;
        key[K_UP]    =  ext && code == SC_UP;
        key[K_ENTER] = !ext && code == SC_ENTER;
        key[K_ESC]   = !ext && code == SC_ESC;
        key[K_P]     = !ext && code == SC_P;
    end

endmodule

// File: rtl/kb_scancode_decoder.sv
// kb_scancode_decoder: Set-2 make/break/extended parser with held-key tracking,
// press/release pulses, typematic suppression and prefix timeout.
module kb_scancode_decoder
    import kb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int SKIP_BYTES     = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          keycode,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                seq_error
);

    localparam int TW = TIMEOUT_CYCLES > 2 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int SW = SKIP_BYTES > 1 ? $clog2(SKIP_BYTES + 1) : 1;

    state_t                state;
    logic [TW-1:0]         tcnt;
    logic [SW-1:0]         scnt;
    logic                  strobe;
    logic                  ext;
    logic [NUM_KEYS-1:0]   hit;

    assign strobe = keycode != 8'h00;
    assign ext    = state == S_EXT || state == S_EXT_BRK;

    kb_key_map u_map (
        .ext  (ext),
        .code (keycode),
        .key  (hit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            tcnt        <= '0;
            scnt        <= '0;
            key_held    <= '0;
            key_press   <= '0;
            key_release <= '0;
            seq_error   <= 1'b0;
        end else begin
            key_press   <= '0;
            key_release <= '0;
            seq_error   <= 1'b0;
            if (strobe) begin
                tcnt <= '0;
                if (keycode == SC_FF) begin
                    key_held    <= '0;
                    key_release <= key_held;
                    seq_error   <= 1'b1;
                    state       <= S_IDLE;
                end else begin
                    case (state)
                        S_IDLE: begin
                            if (keycode == SC_E0) begin
                                state <= S_EXT;
                            end else if (keycode == SC_F0) begin
                                state <= S_BRK;
                            end else if (keycode == SC_E1) begin
                                state <= S_SKIP;
                                scnt  <= SW'(SKIP_BYTES);
                            end else if (!(keycode inside {SC_FA, SC_AA, SC_EE})) begin
                                key_held  <= key_held | hit;
                                key_press <= hit & ~key_held;
                            end
                        end
                        S_EXT: begin
                            if (keycode == SC_F0) begin
                                state <= S_EXT_BRK;
                            end else if (keycode != SC_E0) begin
                                key_held  <= key_held | hit;
                                key_press <= hit & ~key_held;
                                state     <= S_IDLE;
                            end
                        end
                        S_BRK: begin
                            if (keycode == SC_F0) begin
                                seq_error <= 1'b1;
                            end else if (keycode == SC_E0) begin
                                seq_error <= 1'b1;
                                state     <= S_EXT;
                            end else begin
                                key_held    <= key_held & ~hit;
                                key_release <= hit & key_held;
                                state       <= S_IDLE;
                            end
                        end
                        S_EXT_BRK: begin
                            if (keycode == SC_F0 || keycode == SC_E0) begin
                                seq_error <= 1'b1;
                            end else begin
                                key_held    <= key_held & ~hit;
                                key_release <= hit & key_held;
                            end
                            state <= S_IDLE;
                        end
                        S_SKIP: begin
                            scnt <= scnt - 1'b1;
                            if (scnt <= SW'(1)) state <= S_IDLE;
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end else if (state == S_IDLE) begin
                tcnt <= '0;
            end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                // abandoned prefix: drop it, keep held keys as they are
                state     <= S_IDLE;
                seq_error <= 1'b1;
                tcnt      <= '0;
            end else if (tcnt != '1) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

endmodule
